// File: rtl/update_pkg.sv
// Shared definitions for the update path: arbiter state encoding, requester
// port indices, default counter width and the signature beat payload.
package update_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_RUN     = 3'd2,
    ST_RELEASE = 3'd3
  } arb_state_e;

  localparam int unsigned PORT_DOCKED  = 0;
  localparam int unsigned PORT_SERIAL  = 1;
  localparam int unsigned CNT_BITS_DEF = 16;
  localparam int unsigned BYTE_BITS    = 8;

  typedef struct packed {
    logic [BYTE_BITS-1:0] data;
    logic                 last;
  } sig_beat_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not granted last.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       gnt_valid_c_o,
  output logic       gnt_id_c_o
);

  always_comb begin
    gnt_valid_c_o = |req_i;
    gnt_id_c_o    = 1'b0;
    case (req_i)
      2'b01:   gnt_id_c_o = 1'b0;
      2'b10:   gnt_id_c_o = 1'b1;
      2'b11:   gnt_id_c_o = ~last_grant_i;
      default: gnt_id_c_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ml_dsa87_verify_arbiter.sv
// Shares one ML-DSA-87 verifier between the docked update agent and the
// serial field-update loader; one transaction at a time, round-robin.
module ml_dsa87_verify_arbiter
  import update_pkg::*;
#(
  parameter int unsigned MSG_HASH_BITS = 256,
  parameter int unsigned START_TIMEOUT = 1024,
  parameter int unsigned CNT_BITS      = CNT_BITS_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 req_valid,
  input  logic [2*MSG_HASH_BITS-1:0] req_hash,
  input  logic [1:0]                 req_use_tssp,
  input  logic [15:0]                req_key_slot,
  output logic [1:0]                 req_ack,
  input  logic [15:0]                req_sig_data,
  input  logic [1:0]                 req_sig_valid,
  input  logic [1:0]                 req_sig_last,
  output logic [1:0]                 req_sig_ready,
  output logic [1:0]                 res_done,
  output logic                       res_pass,
  output logic                       res_error,
  output logic                       v_verify_start,
  output logic [MSG_HASH_BITS-1:0]   v_msg_hash,
  output logic                       v_use_tssp,
  output logic [7:0]                 v_key_slot,
  output logic [7:0]                 v_sig_data,
  output logic                       v_sig_valid,
  output logic                       v_sig_last,
  input  logic                       v_sig_ready,
  input  logic                       v_verify_done,
  input  logic                       v_verify_pass,
  input  logic                       v_verify_error,
  input  logic                       v_busy,
  output logic                       grant_id,
  output logic [2:0]                 arb_state,
  output logic [2*CNT_BITS-1:0]      pass_cnt,
  output logic [2*CNT_BITS-1:0]      fail_cnt
);

  localparam int unsigned TMR_BITS = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  arb_state_e                  state_q, state_d;
  logic [TMR_BITS-1:0]         timer_q, timer_d;
  logic                        grant_q, grant_d;
  logic                        last_grant_q, last_grant_d;
  logic [MSG_HASH_BITS-1:0]    hash_q, hash_d;
  logic                        tssp_q, tssp_d;
  logic [7:0]                  key_q, key_d;
  logic                        start_q, start_d;
  logic [1:0]                  ack_q, ack_d;
  logic [1:0]                  done_q, done_d;
  logic                        pass_q, pass_d;
  logic                        err_q, err_d;
  logic [1:0][CNT_BITS-1:0]    pass_cnt_q, pass_cnt_d;
  logic [1:0][CNT_BITS-1:0]    fail_cnt_q, fail_cnt_d;

  logic                        arb_valid_c;
  logic                        arb_id_c;
  logic                        res_fire_c;
  logic                        res_pass_c;
  logic                        res_err_c;
  sig_beat_t [1:0]             beat_c;
  sig_beat_t                   beat_sel_c;

  rr_arb2 u_rr_arb2 (
    .req_i         (req_valid),
    .last_grant_i  (last_grant_q),
    .gnt_valid_c_o (arb_valid_c),
    .gnt_id_c_o    (arb_id_c)
  );

  assign beat_c[0] = '{data: req_sig_data[7:0],  last: req_sig_last[0]};
  assign beat_c[1] = '{data: req_sig_data[15:8], last: req_sig_last[1]};

  // Signature stream only flows to the verifier while the granted port is running.
  always_comb begin
    beat_sel_c    = beat_c[grant_q];
    v_sig_data    = '0;
    v_sig_valid   = 1'b0;
    v_sig_last    = 1'b0;
    req_sig_ready = '0;
    if (state_q == ST_RUN) begin
      v_sig_data             = beat_sel_c.data;
      v_sig_valid            = req_sig_valid[grant_q];
      v_sig_last             = beat_sel_c.last;
      req_sig_ready[grant_q] = v_sig_ready;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    hash_d       = hash_q;
    tssp_d       = tssp_q;
    key_d        = key_q;
    start_d      = start_q;
    ack_d        = '0;
    done_d       = '0;
    pass_d       = 1'b0;
    err_d        = 1'b0;
    pass_cnt_d   = pass_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    res_fire_c   = 1'b0;
    res_pass_c   = 1'b0;
    res_err_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid_c) begin
          grant_d         = arb_id_c;
          hash_d          = arb_id_c ? req_hash[2*MSG_HASH_BITS-1:MSG_HASH_BITS]
                                     : req_hash[MSG_HASH_BITS-1:0];
          tssp_d          = req_use_tssp[arb_id_c];
          key_d           = arb_id_c ? req_key_slot[15:8] : req_key_slot[7:0];
          ack_d[arb_id_c] = 1'b1;
          start_d         = 1'b1;
          timer_d         = '0;
          state_d         = ST_START;
        end
      end
      ST_START: begin
        if (v_busy) begin
          timer_d = '0;
          state_d = ST_RUN;
        end else if (timer_q == TMR_BITS'(START_TIMEOUT - 1)) begin
          res_fire_c = 1'b1;
          res_err_c  = 1'b1;
          start_d    = 1'b0;
          state_d    = ST_RELEASE;
        end else begin
          timer_d = timer_q + TMR_BITS'(1);
        end
      end
      ST_RUN: begin
        if (v_verify_done || v_verify_error) begin
          res_fire_c = 1'b1;
          res_pass_c = v_verify_pass & ~v_verify_error;
          res_err_c  = v_verify_error;
          start_d    = 1'b0;
          state_d    = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // The verifier lowers done/error a cycle late; leaving early would
        // hand a stale result to the next requester.
        if (!v_verify_done && !v_verify_error) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (res_fire_c) begin
      done_d[grant_q] = 1'b1;
      pass_d          = res_pass_c;
      err_d           = res_err_c;
      if (res_pass_c) begin
        if (pass_cnt_q[grant_q] != '1) pass_cnt_d[grant_q] = pass_cnt_q[grant_q] + CNT_BITS'(1);
      end else begin
        if (fail_cnt_q[grant_q] != '1) fail_cnt_d[grant_q] = fail_cnt_q[grant_q] + CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      grant_q      <= 1'(PORT_DOCKED);
      last_grant_q <= 1'(PORT_SERIAL);
      hash_q       <= '0;
      tssp_q       <= 1'b0;
      key_q        <= '0;
      start_q      <= 1'b0;
      ack_q        <= '0;
      done_q       <= '0;
      pass_q       <= 1'b0;
      err_q        <= 1'b0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      hash_q       <= hash_d;
      tssp_q       <= tssp_d;
      key_q        <= key_d;
      start_q      <= start_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
    end
  end

  assign req_ack        = ack_q;
  assign res_done       = done_q;
  assign res_pass       = pass_q;
  assign res_error      = err_q;
  assign v_verify_start = start_q;
  assign v_msg_hash     = hash_q;
  assign v_use_tssp     = tssp_q;
  assign v_key_slot     = key_q;
  assign grant_id       = grant_q;
  assign arb_state      = state_q;
  assign pass_cnt       = pass_cnt_q;
  assign fail_cnt       = fail_cnt_q;

endmodule

// File: tb/tb_ml_dsa87_verify_arbiter.sv
// Randomized bench for ml_dsa87_verify_arbiter: the bench plays both
// requesters and the verifier and checks against a transaction-level model.
module tb_ml_dsa87_verify_arbiter;

  localparam int unsigned HB   = 256;
  localparam int unsigned TO   = 1024;
  localparam int unsigned CB   = 4;
  localparam int          CMAX = (1 << CB) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [2*HB-1:0] req_hash;
  logic [1:0]      req_use_tssp;
  logic [15:0]     req_key_slot;
  logic [1:0]      req_ack;
  logic [15:0]     req_sig_data;
  logic [1:0]      req_sig_valid;
  logic [1:0]      req_sig_last;
  logic [1:0]      req_sig_ready;
  logic [1:0]      res_done;
  logic            res_pass;
  logic            res_error;
  logic            v_verify_start;
  logic [HB-1:0]   v_msg_hash;
  logic            v_use_tssp;
  logic [7:0]      v_key_slot;
  logic [7:0]      v_sig_data;
  logic            v_sig_valid;
  logic            v_sig_last;
  logic            v_sig_ready;
  logic            v_verify_done;
  logic            v_verify_pass;
  logic            v_verify_error;
  logic            v_busy;
  logic            grant_id;
  logic [2:0]      arb_state;
  logic [2*CB-1:0] pass_cnt;
  logic [2*CB-1:0] fail_cnt;

  int checks = 0;
  int passed = 0;
  int last_m;
  int pass_m [2];
  int fail_m [2];
  int gap_m;
  logic [HB-1:0] hash_m [2];
  logic          tssp_m [2];
  logic [7:0]    key_m  [2];

  always #5 clk = ~clk;

  ml_dsa87_verify_arbiter #(
    .MSG_HASH_BITS (HB),
    .START_TIMEOUT (TO),
    .CNT_BITS      (CB)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_hash       (req_hash),
    .req_use_tssp   (req_use_tssp),
    .req_key_slot   (req_key_slot),
    .req_ack        (req_ack),
    .req_sig_data   (req_sig_data),
    .req_sig_valid  (req_sig_valid),
    .req_sig_last   (req_sig_last),
    .req_sig_ready  (req_sig_ready),
    .res_done       (res_done),
    .res_pass       (res_pass),
    .res_error      (res_error),
    .v_verify_start (v_verify_start),
    .v_msg_hash     (v_msg_hash),
    .v_use_tssp     (v_use_tssp),
    .v_key_slot     (v_key_slot),
    .v_sig_data     (v_sig_data),
    .v_sig_valid    (v_sig_valid),
    .v_sig_last     (v_sig_last),
    .v_sig_ready    (v_sig_ready),
    .v_verify_done  (v_verify_done),
    .v_verify_pass  (v_verify_pass),
    .v_verify_error (v_verify_error),
    .v_busy         (v_busy),
    .grant_id       (grant_id),
    .arb_state      (arb_state),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt)
  );

  function automatic logic [HB-1:0] rand_hash();
    logic [HB-1:0] h;
    for (int i = 0; i < int'(HB / 32); i++) h[i*32 +: 32] = $urandom;
    return h;
  endfunction

  // Expected winner: lone requester wins, tie goes to the port not granted last.
  function automatic int pick(input logic [1:0] r, input int last);
    if (r == 2'b11) return 1 - last;
    return r[1] ? 1 : 0;
  endfunction

  task automatic clear_inputs();
    req_valid      = '0;
    req_hash       = '0;
    req_use_tssp   = '0;
    req_key_slot   = '0;
    req_sig_data   = '0;
    req_sig_valid  = '0;
    req_sig_last   = '0;
    v_sig_ready    = 1'b0;
    v_verify_done  = 1'b0;
    v_verify_pass  = 1'b0;
    v_verify_error = 1'b0;
    v_busy         = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    last_m = 1;
    pass_m = '{0, 0};
    fail_m = '{0, 0};
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input logic [HB-1:0] h);
    hash_m[p] = h;
    tssp_m[p] = 1'($urandom);
    key_m[p]  = 8'($urandom);
    req_hash[p*HB +: HB]   = h;
    req_use_tssp[p]        = tssp_m[p];
    req_key_slot[p*8 +: 8] = key_m[p];
    req_valid[p]           = 1'b1;
  endtask

  task automatic take_grant(input int exp_p, output bit ok);
    int got;
    int cyc;
    logic [1:0] ack_exp;
    got = -1;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (req_ack !== 2'b00) begin
        got = req_ack[1] ? 1 : 0;
        break;
      end
    end
    gap_m = cyc;
    ack_exp = 2'b00;
    ack_exp[exp_p] = 1'b1;
    checks++;
    if (got != exp_p || req_ack !== ack_exp || grant_id !== 1'(exp_p) ||
        v_msg_hash !== hash_m[exp_p] || v_use_tssp !== tssp_m[exp_p] ||
        v_key_slot !== key_m[exp_p] || v_verify_start !== 1'b1) begin
      $display("FAIL grant: port=%0d ack=%b gid=%b start=%b tssp=%b key=%h hash_ok=%0d, required port=%0d ack=%b start=1 tssp=%b key=%h",
               got, req_ack, grant_id, v_verify_start, v_use_tssp, v_key_slot,
               v_msg_hash === hash_m[exp_p], exp_p, ack_exp, tssp_m[exp_p], key_m[exp_p]);
    end else passed++;
    ok = (got == exp_p);
    if (got >= 0) req_valid[got] = 1'b0;
  endtask

  // Plays the verifier for one granted transaction; outcome 0 pass, 1 mismatch, 2 error, 3 no busy.
  task automatic serve(input int p, input int outcome, input int nbytes);
    int o;
    int bad;
    int i;
    int cyc;
    logic [7:0] b;
    logic lst;
    logic [1:0] done_exp;
    o = 1 - p;
    done_exp = 2'b00;
    done_exp[p] = 1'b1;
    req_sig_valid = 2'b11;
    #1;
    checks++;
    if (v_sig_valid !== 1'b0 || req_sig_ready !== 2'b00 || v_verify_start !== 1'b1) begin
      $display("FAIL start_phase: v_sig_valid=%b req_sig_ready=%b v_verify_start=%b, required 0 00 1",
               v_sig_valid, req_sig_ready, v_verify_start);
    end else passed++;
    req_hash[p*HB +: HB] = rand_hash();
    if (outcome == 3) begin
      cyc = 0;
      while (res_done === 2'b00 && cyc < int'(TO) + 16) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (cyc != int'(TO) || res_done !== done_exp || res_error !== 1'b1 ||
          res_pass !== 1'b0 || v_verify_start !== 1'b0) begin
        $display("FAIL timeout: cycles=%0d res_done=%b err=%b pass=%b start=%b, required cycles=%0d res_done=%b err=1 pass=0 start=0",
                 cyc, res_done, res_error, res_pass, v_verify_start, TO, done_exp);
      end else passed++;
      req_sig_valid = 2'b00;
      if (fail_m[p] < CMAX) fail_m[p]++;
    end else begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      v_busy = 1'b1;
      @(negedge clk);
      checks++;
      if (arb_state !== 3'd2) $display("FAIL run_state: arb_state=%0d, required 2", arb_state);
      else passed++;
      bad = 0;
      i = 0;
      while (i < nbytes) begin
        b   = 8'($urandom);
        lst = (i == nbytes - 1);
        req_sig_data[p*8 +: 8] = b;
        req_sig_last[p]        = lst;
        req_sig_data[o*8 +: 8] = 8'($urandom);
        req_sig_last[o]        = 1'($urandom);
        req_sig_valid          = 2'b11;
        v_sig_ready            = ($urandom_range(0, 3) != 0);
        #1;
        if (v_sig_valid !== 1'b1 || v_sig_data !== b || v_sig_last !== lst ||
            req_sig_ready[p] !== v_sig_ready || req_sig_ready[o] !== 1'b0) bad++;
        if (v_sig_ready) i++;
        @(negedge clk);
      end
      checks++;
      if (bad != 0) $display("FAIL stream: port=%0d bad_beats=%0d, required 0", p, bad);
      else passed++;
      req_sig_valid = 2'b00;
      req_sig_last  = 2'b00;
      v_sig_ready   = 1'b0;
      if (outcome == 2) begin
        v_verify_error = 1'b1;
        v_verify_done  = 1'($urandom);
        v_verify_pass  = 1'($urandom);
      end else begin
        v_verify_done = 1'b1;
        v_verify_pass = (outcome == 0);
      end
      @(negedge clk);
      checks++;
      if (res_done !== done_exp || res_pass !== (outcome == 0) || res_error !== (outcome == 2) ||
          v_verify_start !== 1'b0 || arb_state !== 3'd3) begin
        $display("FAIL result: res_done=%b pass=%b err=%b start=%b state=%0d, required res_done=%b pass=%0d err=%0d start=0 state=3",
                 res_done, res_pass, res_error, v_verify_start, arb_state, done_exp,
                 outcome == 0, outcome == 2);
      end else passed++;
      v_busy = 1'b0;
      bad = 0;
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        if (res_done !== 2'b00 || res_pass !== 1'b0 || res_error !== 1'b0 ||
            req_ack !== 2'b00 || arb_state !== 3'd3) bad++;
      end
      checks++;
      if (bad != 0) $display("FAIL stale_hold: bad_cycles=%0d, required 0 (no pulse, no grant, stay in RELEASE)", bad);
      else passed++;
      v_verify_done  = 1'b0;
      v_verify_error = 1'b0;
      v_verify_pass  = 1'b0;
      if (outcome == 0) begin
        if (pass_m[p] < CMAX) pass_m[p]++;
      end else begin
        if (fail_m[p] < CMAX) fail_m[p]++;
      end
    end
    last_m = p;
    checks++;
    if (v_msg_hash !== hash_m[p] || pass_cnt !== {CB'(pass_m[1]), CB'(pass_m[0])} ||
        fail_cnt !== {CB'(fail_m[1]), CB'(fail_m[0])}) begin
      $display("FAIL counters_hash: hash_ok=%0d pass_cnt=%h fail_cnt=%h, required pass_cnt=%h fail_cnt=%h",
               v_msg_hash === hash_m[p], pass_cnt, fail_cnt,
               {CB'(pass_m[1]), CB'(pass_m[0])}, {CB'(fail_m[1]), CB'(fail_m[0])});
    end else passed++;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (req_ack !== 0 || req_sig_ready !== 0 || res_done !== 0 || res_pass !== 0 ||
        res_error !== 0 || v_verify_start !== 0 || v_msg_hash !== 0 || v_use_tssp !== 0 ||
        v_key_slot !== 0 || v_sig_valid !== 0 || v_sig_data !== 0 || v_sig_last !== 0 ||
        grant_id !== 0 || arb_state !== 0 || pass_cnt !== 0 || fail_cnt !== 0) begin
      $display("FAIL reset_state: ack=%b done=%b start=%b gid=%b state=%0d pass_cnt=%h fail_cnt=%h, required all 0",
               req_ack, res_done, v_verify_start, grant_id, arb_state, pass_cnt, fail_cnt);
    end else passed++;
  endtask

  task automatic test_single();
    bit ok;
    logic [HB-1:0] h;
    h = {(HB/8){8'hA5}};
    set_req(0, h);
    take_grant(pick(req_valid, last_m), ok);
    if (ok) serve(0, 0, 4627);
    checks++;
    if (pass_cnt[CB-1:0] !== CB'(1)) $display("FAIL single_pass_cnt: %0d, required 1", pass_cnt[CB-1:0]);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int g;
    do_reset();
    repeat (2) begin
      set_req(0, rand_hash());
      set_req(1, rand_hash());
      g = pick(req_valid, last_m);
      take_grant(g, ok);
      if (ok) serve(g, $urandom_range(0, 2), $urandom_range(1, 8));
      g = pick(req_valid, last_m);
      take_grant(g, ok);
      checks++;
      if (gap_m != 2) $display("FAIL grant_gap: cycles=%0d, required 2", gap_m);
      else passed++;
      if (ok) serve(g, $urandom_range(0, 2), $urandom_range(1, 8));
    end
  endtask

  task automatic test_mux();
    bit ok;
    set_req(1, rand_hash());
    take_grant(pick(req_valid, last_m), ok);
    if (ok) serve(1, 1, 64);
  endtask

  task automatic test_error();
    bit ok;
    set_req(0, rand_hash());
    take_grant(pick(req_valid, last_m), ok);
    set_req(1, rand_hash());
    if (ok) serve(0, 2, 8);
    take_grant(pick(req_valid, last_m), ok);
    if (ok) serve(1, 0, 4);
  endtask

  task automatic test_timeout();
    bit ok;
    set_req(1, rand_hash());
    take_grant(pick(req_valid, last_m), ok);
    if (ok) serve(1, 3, 0);
  endtask

  task automatic test_saturation();
    bit ok;
    for (int k = 0; k < CMAX + 2; k++) begin
      set_req(1, rand_hash());
      take_grant(pick(req_valid, last_m), ok);
      if (!ok) break;
      serve(1, $urandom_range(1, 2), 2);
    end
    checks++;
    if (fail_cnt[2*CB-1:CB] !== CB'(CMAX)) $display("FAIL fail_saturate: %0d, required %0d", fail_cnt[2*CB-1:CB], CMAX);
    else passed++;
  endtask

  task automatic test_random();
    bit ok;
    int g;
    logic [1:0] mask;
    for (int it = 0; it < 16; it++) begin
      mask = 2'($urandom_range(1, 3));
      if (mask[0]) set_req(0, rand_hash());
      if (mask[1]) set_req(1, rand_hash());
      for (int k = 0; k < 2 && req_valid != 2'b00; k++) begin
        g = pick(req_valid, last_m);
        take_grant(g, ok);
        if (!ok) break;
        serve(g, $urandom_range(0, 2), $urandom_range(1, 12));
      end
      req_valid = 2'b00;
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    set_req(1, rand_hash());
    take_grant(pick(req_valid, last_m), ok);
    v_busy        = 1'b1;
    req_sig_valid = 2'b11;
    v_sig_ready   = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ack !== 0 || req_sig_ready !== 0 || res_done !== 0 || res_pass !== 0 ||
        res_error !== 0 || v_verify_start !== 0 || v_msg_hash !== 0 || v_use_tssp !== 0 ||
        v_key_slot !== 0 || v_sig_valid !== 0 || v_sig_data !== 0 || v_sig_last !== 0 ||
        grant_id !== 0 || arb_state !== 0 || pass_cnt !== 0 || fail_cnt !== 0) begin
      $display("FAIL reset_mid_run: ready=%b start=%b v_sig_valid=%b gid=%b state=%0d pass_cnt=%h fail_cnt=%h, required all 0",
               req_sig_ready, v_verify_start, v_sig_valid, grant_id, arb_state, pass_cnt, fail_cnt);
    end else passed++;
    do_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_mux();
    test_error();
    test_timeout();
    test_saturation();
    test_random();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
